// File: rtl/debug_pkg.sv
// Shared command codes and state encodings for the debug load controller.
package debug_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_HALT = 8'h04;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_LEN  = 3'd1,
    ST_LOAD_DATA = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4,
    ST_LOAD_CHK  = 3'd5
  } state_t;

endpackage

// File: rtl/debug_load_ctrl.sv
// Debug command sequencer: decodes commands, streams program words into imem, gates the CPU enable.
// Optional load checksum stage enabled by defining DEBUG_LOAD_CHECKSUM_EN.
module debug_load_ctrl
  import debug_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_word_valid,
  input  logic              i_cpu_halted,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [DATA_W-1:0] o_imem_data,
  output logic              o_cpu_en,
  output logic              o_busy,
  output logic              o_load_done,
  output logic              o_cmd_err,
  output logic [2:0]        o_state
);

  // Length must hold IMEM_DEPTH itself, so it is one bit wider than the address when depth is a power of two.
  localparam int unsigned LEN_W = $clog2(IMEM_DEPTH + 1);

  state_t           state, state_nx;
  logic [LEN_W-1:0] len, len_nx, cnt, cnt_nx;
  logic             we_nx, done_nx, err_nx, en_nx;
  logic [7:0]       cmd;
  logic             last_word, run_exit, len_zero, len_big;

  assign cmd       = i_word[7:0];
  assign last_word = ((cnt + LEN_W'(1)) == len);
  assign run_exit  = i_cpu_halted || (i_word_valid && (cmd == CMD_HALT));
  assign len_zero  = (i_word == '0);
  assign len_big   = (i_word > DATA_W'(IMEM_DEPTH));

`ifdef DEBUG_LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                               sum <= '0;
    else if (state == ST_LOAD_LEN)                sum <= '0;
    else if (state == ST_LOAD_DATA && i_word_valid) sum <= sum + i_word;
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      len         <= '0;
      cnt         <= '0;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_cpu_en    <= 1'b0;
      o_load_done <= 1'b0;
      o_cmd_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      len         <= len_nx;
      cnt         <= cnt_nx;
      o_imem_we   <= we_nx;
      o_cpu_en    <= en_nx;
      o_load_done <= done_nx;
      o_cmd_err   <= err_nx;
      if (we_nx) begin
        o_imem_addr <= cnt[ADDR_W-1:0];
        o_imem_data <= i_word;
      end
    end
  end

  always_comb begin
    state_nx = state;
    len_nx   = len;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE:
        if (i_word_valid) begin
          case (cmd)
            CMD_LOAD: state_nx = ST_LOAD_LEN;
            CMD_RUN:  state_nx = ST_RUN;
            CMD_STEP: state_nx = ST_STEP;
            default:  state_nx = ST_IDLE;
          endcase
        end
      ST_LOAD_LEN:
        if (i_word_valid) begin
          if (len_zero) begin
`ifdef DEBUG_LOAD_CHECKSUM_EN
            state_nx = ST_LOAD_CHK;
`else
            state_nx = ST_IDLE;
`endif
          end else if (len_big) begin
            state_nx = ST_IDLE;
          end else begin
            len_nx   = i_word[LEN_W-1:0];
            cnt_nx   = '0;
            state_nx = ST_LOAD_DATA;
          end
        end
      ST_LOAD_DATA:
        if (i_word_valid) begin
          cnt_nx = cnt + LEN_W'(1);
          if (last_word) begin
`ifdef DEBUG_LOAD_CHECKSUM_EN
            state_nx = ST_LOAD_CHK;
`else
            state_nx = ST_IDLE;
`endif
          end
        end
      ST_RUN:      if (run_exit) state_nx = ST_IDLE;
      ST_STEP:     state_nx = ST_IDLE;
`ifdef DEBUG_LOAD_CHECKSUM_EN
      ST_LOAD_CHK: if (i_word_valid) state_nx = ST_IDLE;
`endif
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    we_nx   = 1'b0;
    done_nx = 1'b0;
    err_nx  = 1'b0;
    en_nx   = 1'b0;
    case (state)
      ST_IDLE:
        if (i_word_valid && !(cmd inside {CMD_LOAD, CMD_RUN, CMD_STEP, CMD_HALT}))
          err_nx = 1'b1;
      ST_LOAD_LEN:
        if (i_word_valid) begin
`ifndef DEBUG_LOAD_CHECKSUM_EN
          done_nx = len_zero;
`endif
          err_nx  = !len_zero && len_big;
        end
      ST_LOAD_DATA:
        if (i_word_valid) begin
          we_nx = 1'b1;
`ifndef DEBUG_LOAD_CHECKSUM_EN
          done_nx = last_word;
`endif
        end
      ST_RUN: begin
        en_nx  = !run_exit;
        err_nx = i_word_valid && (cmd != CMD_HALT);
      end
      // Enable is registered, so the single step pulse appears as the FSM lands back in IDLE.
      ST_STEP:     en_nx = !i_cpu_halted;
`ifdef DEBUG_LOAD_CHECKSUM_EN
      ST_LOAD_CHK:
        if (i_word_valid) begin
          done_nx = (i_word == sum);
          err_nx  = (i_word != sum);
        end
`endif
      default: ;
    endcase
  end

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_debug_load_ctrl.sv
// Self-checking bench for debug_load_ctrl: directed test-plan sequences then randomized traffic vs. a reference model.
module tb_debug_load_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word = '0;
  logic        valid = 1'b0;
  logic        halted = 1'b0;

  logic        o_imem_we, o_cpu_en, o_busy, o_load_done, o_cmd_err;
  logic [7:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic [2:0]  o_state;

  int total = 0;
  int bad = 0;

  // Reference model: mode numbers are the documented debug-dump codes.
  int          m_mode;
  int          m_left;
  int          m_next_addr;
  logic [31:0] m_sum;
  logic        e_we, e_done, e_err, e_en;
  logic [31:0] e_addr, e_data;

  always #5 clk = ~clk;

  debug_load_ctrl #(.DATA_W(32), .IMEM_DEPTH(DEPTH), .ADDR_W(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_word(word), .i_word_valid(valid),
    .i_cpu_halted(halted), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_data(o_imem_data), .o_cpu_en(o_cpu_en), .o_busy(o_busy),
    .o_load_done(o_load_done), .o_cmd_err(o_cmd_err), .o_state(o_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_next_addr = 0; m_sum = '0;
    e_we = 0; e_done = 0; e_err = 0; e_en = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic load_finished();
`ifdef DEBUG_LOAD_CHECKSUM_EN
    m_mode = 5;
`else
    e_done = 1; m_mode = 0;
`endif
  endtask

  task automatic model_step(input logic [31:0] w, input logic v, input logic h);
    int c;
    c = int'(w & 32'hFF);
    e_we = 0; e_done = 0; e_err = 0; e_en = 0;
    case (m_mode)
      0: if (v) begin
           if (c == 1) m_mode = 1;
           else if (c == 2) m_mode = 3;
           else if (c == 3) m_mode = 4;
           else if (c != 4) e_err = 1;
         end
      1: if (v) begin
           m_sum = '0;
           if (w == 0) load_finished();
           else if (w > DEPTH) begin e_err = 1; m_mode = 0; end
           else begin m_left = int'(w); m_next_addr = 0; m_mode = 2; end
         end
      2: if (v) begin
           e_we = 1; e_addr = m_next_addr; e_data = w;
           m_next_addr++; m_sum += w; m_left--;
           if (m_left == 0) load_finished();
         end
      3: begin
           if (v && c != 4) e_err = 1;
           if (h || (v && c == 4)) m_mode = 0;
           else e_en = 1;
         end
      4: begin e_en = !h; m_mode = 0; end
      5: if (v) begin
           if (w == m_sum) e_done = 1; else e_err = 1;
           m_mode = 0;
         end
      default: m_mode = 0;
    endcase
  endtask

  task automatic step(input logic [31:0] w, input logic v, input logic h);
    word = w; valid = v; halted = h;
    @(posedge clk);
    model_step(w, v, h);
    #1;
    check("imem_we", o_imem_we, e_we);
    check("load_done", o_load_done, e_done);
    check("cmd_err", o_cmd_err, e_err);
    check("cpu_en", o_cpu_en, e_en);
    check("state", o_state, m_mode);
    check("busy", o_busy, m_mode != 0);
    if (e_we) begin
      check("imem_addr", o_imem_addr, e_addr);
      check("imem_data", o_imem_data, e_data);
    end
  endtask

  task automatic send(input logic [31:0] w);
    step(w, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_we", o_imem_we, 0);
    check("rst_addr", o_imem_addr, 0);
    check("rst_data", o_imem_data, 0);
    check("rst_en", o_cpu_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_load_done, 0);
    check("rst_err", o_cmd_err, 0);
    check("rst_state", o_state, 0);
  endtask

  // Asserts reset between clock edges and releases it before the next rising edge.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    valid = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [31:0] w;
    model_reset();
    #12 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h01); send(32'h3); send(32'hA); send(32'hB); send(32'hC); idle(3);
    send(32'h01); send(32'h0); idle(2);
    send(32'h01); send(32'd257); idle(2);
    send(32'hAB01); send(32'd256);
    for (int i = 0; i < 256; i++) send(32'h0100_0000 + i);
    idle(2);

    send(32'h02);
    for (int i = 0; i < 11; i++) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1); step('0, 1'b0, 1'b1); idle(2);
    send(32'h02); idle(4); send(32'h55); idle(2); send(32'h04); idle(3);
    send(32'h02); step(32'h04, 1'b1, 1'b1); idle(2);
    send(32'h02); step('0, 1'b0, 1'b1); idle(2);

    send(32'h03); idle(3);
    send(32'h03); step('0, 1'b0, 1'b1); idle(2);
    send(32'h7F); idle(2);
    send(32'hFFFF_FF04); idle(1);

    send(32'h01); send(32'h5); send(32'h11); send(32'h22);
    pulse_reset();
    send(32'h01); send(32'h2); send(32'h33); send(32'h44); idle(2);

    send(32'h01); send(32'h2); send(32'h1); send(32'h2); send(32'h3); idle(2);
    send(32'h01); send(32'h2); send(32'h1); send(32'h2); send(32'h4); idle(2);
    send(32'h01); send(32'h0); send(32'h0); idle(2);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      w = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 5);
      else if (r < 70) w = $urandom_range(0, 6);
      else if (r < 73) w = $urandom_range(255, 258);
      else             w = $urandom;
      step(w, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 599) == 0) pulse_reset();
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_load_ctrl.md
Name: debug_load_ctrl

Overview:
- Command sequencer for the debug unit. It sits downstream of the UART word assembler, which delivers one 32-bit word plus a one-cycle valid pulse.
- Decodes command words and streams program words into instruction memory with auto-incrementing addresses.
- Gates the pipeline clock-enable for RUN and single STEP, and returns to idle on HALT or on the CPU halt flag.

Parameters:
- DATA_W, 32, width of received words and instruction-memory data.
- IMEM_DEPTH, 256, instruction-memory depth in words.
- ADDR_W, 8, instruction-memory word-address width; must satisfy 2^ADDR_W >= IMEM_DEPTH.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_word  in  DATA_W  assembled word from the word assembler
- i_word_valid  in  1  one-cycle pulse: i_word is valid this cycle
- i_cpu_halted  in  1  CPU has retired its HALT instruction (level)
- o_imem_we  out  1  instruction-memory write enable (one-cycle pulse)
- o_imem_addr  out  ADDR_W  instruction-memory write word address
- o_imem_data  out  DATA_W  instruction-memory write data
- o_cpu_en  out  1  pipeline advance enable
- o_busy  out  1  high in any state other than IDLE
- o_load_done  out  1  one-cycle pulse when a load completes
- o_cmd_err  out  1  one-cycle pulse on a bad command, bad length or checksum failure
- o_state  out  3  current state encoding, for the debug dump

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; all outputs 0; word counter and address 0.
- Command codes (low byte of the word; upper bits ignored): LOAD=0x01, RUN=0x02, STEP=0x03, HALT=0x04.
- Word handling:
  - Words are consumed only on cycles with i_word_valid=1.
  - No backpressure exists. Every word is handled in the cycle it arrives; registered outputs update one cycle later.
- IDLE:
  - LOAD -> LOAD_LEN.
  - RUN -> RUN.
  - STEP -> STEP.
  - HALT -> stay in IDLE, no effect.
  - Any other code -> o_cmd_err pulse, stay in IDLE.
- LOAD_LEN: the next word is length N.
  - N=0: o_load_done pulse, -> IDLE.
  - N>IMEM_DEPTH: o_cmd_err pulse, -> IDLE.
  - Otherwise: latch N, clear addr to 0, -> LOAD_DATA.
- LOAD_DATA: each valid word is written to memory.
  - Next cycle: o_imem_we=1, o_imem_data=word, o_imem_addr=current addr; then addr increments.
  - After the Nth write: o_load_done pulses in the same cycle as the last o_imem_we, -> IDLE.
  - No address wrap is possible, because N<=IMEM_DEPTH is enforced.
  - Command codes arriving in LOAD_DATA are treated as data.
- RUN:
  - o_cpu_en=1 from the cycle after entry.
  - Exit to IDLE, o_cpu_en=0 the following cycle, on either a HALT word or i_cpu_halted=1.
  - If both occur in the same cycle, exit once with no error.
  - Non-HALT words in RUN: o_cmd_err pulse, stay in RUN.
- STEP:
  - o_cpu_en=1 for exactly one cycle, then -> IDLE.
  - Words arriving during that cycle are dropped.
- i_cpu_halted=1 when entering RUN or STEP: o_cpu_en stays 0, -> IDLE, no error.
- Reset asserted mid-load: the partial load is abandoned. Memory contents are undefined beyond the last completed write.
- o_state encoding: IDLE=0, LOAD_LEN=1, LOAD_DATA=2, RUN=3, STEP=4, LOAD_CHK=5.

Optional Feature:
- Macro: DEBUG_LOAD_CHECKSUM_EN.
- Defined:
  - After the Nth data word, the state goes to LOAD_CHK instead of IDLE, and o_load_done is withheld.
  - The next word is compared with the running sum of the N data words, modulo 2^DATA_W.
  - Match: o_load_done pulse. Mismatch: o_cmd_err pulse. Either way -> IDLE.
  - N=0 also expects a checksum word of 0.
- Undefined: no LOAD_CHK state and no running sum; the load completes on the Nth word as above.

Decomposition:
- Package debug_pkg holds:
  - the command-code localparams: CMD_LOAD, CMD_RUN, CMD_STEP, CMD_HALT;
  - the state encodings;
  - the 3-bit state width.
- No sub-module: a single FSM with an address/length counter. The checksum accumulator stays inline under the macro.

Test Plan:
- Load sequence: words 0x01, 0x3, then 0xA, 0xB, 0xC -> three o_imem_we pulses at addr 0,1,2 with data 0xA,0xB,0xC; o_load_done coincides with the addr-2 write; state returns to 0.
- Length bounds:
  - LOAD with N=0 -> o_load_done pulse, no writes.
  - LOAD with N=257 (IMEM_DEPTH=256) -> o_cmd_err pulse, no writes, IDLE.
- Run control:
  - RUN, then i_cpu_halted=1 after 10 cycles -> o_cpu_en high 10 cycles, then 0.
  - RUN, then a HALT word -> o_cpu_en drops the cycle after the HALT is consumed.
- Step and bad command:
  - STEP -> o_cpu_en high exactly one cycle.
  - Word 0x7F in IDLE -> o_cmd_err pulse, state stays 0.
- Reset mid-operation: i_reset_n low after the 2nd data word of an N=5 load -> all outputs 0 immediately; a following new LOAD writes from addr 0.
- Checksum (with DEBUG_LOAD_CHECKSUM_EN):
  - Data 0x1, 0x2 with checksum 0x3 -> o_load_done pulse.
  - Checksum 0x4 -> o_cmd_err pulse, no o_load_done.
